// File: rtl/fir_coeff_writer_if.sv
// Purpose : host-side control and register-bank write bundle for fir_coeff_writer.
// Latency : n/a (signal bundle only).
// Backpressure: none; the register bank accepts every strobe.
// Ports   : start/abort/coeff_flat from the host; coeff_out/sel_out/en_out to the bank;
//           busy/done status back to the host.
interface fir_coeff_writer_if #(
  parameter int NUM_COEFF = 4,
  parameter int COEFF_W   = 5,
  parameter int SEL_W     = 2
);
  logic                         start;
  logic                         abort;
  logic [NUM_COEFF*COEFF_W-1:0] coeff_flat;
  logic [COEFF_W-1:0]           coeff_out;
  logic [SEL_W-1:0]             sel_out;
  logic                         en_out;
  logic                         busy;
  logic                         done;

  // Host / test side drives the requests and observes the write port.
  modport master (
    output start, abort, coeff_flat,
    input  coeff_out, sel_out, en_out, busy, done
  );

  // The coefficient writer itself.
  modport slave (
    input  start, abort, coeff_flat,
    output coeff_out, sel_out, en_out, busy, done
  );
endinterface

// File: rtl/fir_coeff_writer.sv
// Purpose : snapshots a flat coefficient set on start and writes it slot by slot
//           to the FIR coefficient bank using setup / strobe / hold per slot.
// Latency : first SETUP one cycle after start; 2+GAP cycles per slot; DONE after the last HOLD.
// Backpressure: none; start is ignored unless idle, abort cancels a run on the next edge.
// Ports   : clk, rst_n (async, active-low), bus (fir_coeff_writer_if.slave).
module fir_coeff_writer #(
  parameter int NUM_COEFF = 4,
  parameter int COEFF_W   = 5,
  parameter int SEL_W     = 2,
  parameter int GAP       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_coeff_writer_if.slave  bus
);

  localparam int FLAT_W = NUM_COEFF * COEFF_W;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_COEFF - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [FLAT_W-1:0]  shadow_q, shadow_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Slot extraction with constant part-selects only.
  function automatic logic [COEFF_W-1:0] slot_of(input logic [FLAT_W-1:0] flat,
                                                 input logic [SEL_W-1:0]  i);
    logic [COEFF_W-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_COEFF; j++) begin
      if (i == SEL_W'(j)) r = flat[j*COEFF_W +: COEFF_W];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    sel_d    = sel_q;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          shadow_d = bus.coeff_flat;
          idx_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        gap_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (gap_q == LAST_GAP) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every in-run transition; index and data stay put.
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
    end

    // Outputs are decoded from the next state so they are plain registers.
    // Data/select only move on entry to SETUP, which keeps them stable
    // around the strobe. shadow_d covers the capture cycle of slot 0.
    if (state_d == S_SETUP) begin
      sel_d   = idx_d;
      coeff_d = slot_of(shadow_d, idx_d);
    end
    en_d   = (state_d == S_STROBE);
    busy_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
      coeff_q  <= '0;
      sel_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.coeff_out = coeff_q;
  assign bus.sel_out   = sel_q;
  assign bus.en_out    = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fir_coeff_writer.sv
// Purpose : directed bench for fir_coeff_writer (default build and a GAP=3, 2-slot build).
// Latency : n/a.
// Backpressure: n/a.
module tb_fir_coeff_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_coeff_writer_if #(.NUM_COEFF(4), .COEFF_W(5), .SEL_W(2)) bus_a ();
  fir_coeff_writer_if #(.NUM_COEFF(2), .COEFF_W(5), .SEL_W(2)) bus_b ();

  fir_coeff_writer #(.NUM_COEFF(4), .COEFF_W(5), .SEL_W(2), .GAP(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  fir_coeff_writer #(.NUM_COEFF(2), .COEFF_W(5), .SEL_W(2), .GAP(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_b  = 1'b0;
  int viol   = 0;
  int en_cyc[$];
  int en_sel[$];
  int en_coeff[$];
  int done_cyc[$];
  int busy_cyc[$];
  logic       prev_en;
  logic [1:0] prev_sel;
  logic [4:0] prev_coeff;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic sample(output logic e, output logic b, output logic d,
                        output logic [1:0] s, output logic [4:0] c);
    if (mon_b) begin
      e = bus_b.en_out; b = bus_b.busy; d = bus_b.done;
      s = bus_b.sel_out; c = bus_b.coeff_out;
    end else begin
      e = bus_a.en_out; b = bus_a.busy; d = bus_a.done;
      s = bus_a.sel_out; c = bus_a.coeff_out;
    end
  endtask

  // One clock edge; cycle number = edges since the start edge.
  task automatic step();
    logic e, b, d;
    logic [1:0] s;
    logic [4:0] c;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample(e, b, d, s, c);
    if (e) begin
      en_cyc.push_back(cyc);
      en_sel.push_back(int'(s));
      en_coeff.push_back(int'(c));
    end
    if (d) done_cyc.push_back(cyc);
    if (b) busy_cyc.push_back(cyc);
    if (e && prev_en) viol++;
    if ((e || prev_en) && (s != prev_sel || c != prev_coeff)) viol++;
    prev_en    = e;
    prev_sel   = s;
    prev_coeff = c;
  endtask

  task automatic run_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic begin_run();
    logic e, b, d;
    logic [1:0] s;
    logic [4:0] c;
    en_cyc.delete(); en_sel.delete(); en_coeff.delete();
    done_cyc.delete(); busy_cyc.delete();
    viol = 0;
    cyc  = 0;
    sample(e, b, d, s, c);
    prev_en = e; prev_sel = s; prev_coeff = c;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.coeff_flat = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.coeff_flat = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_en",    int'(bus_a.en_out),    0);
    check("rst_busy",  int'(bus_a.busy),      0);
    check("rst_done",  int'(bus_a.done),      0);
    check("rst_sel",   int'(bus_a.sel_out),   0);
    check("rst_coeff", int'(bus_a.coeff_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full run with defaults
    bus_a.coeff_flat = {5'd4, 5'd3, 5'd2, 5'd1};
    begin_run();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    run_until(16);
    check("run_n_strobe", en_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("run_en_cyc%0d", k), q_at(en_cyc, k),   2 + 3 * k);
      check($sformatf("run_sel%0d", k),    q_at(en_sel, k),   k);
      check($sformatf("run_coeff%0d", k),  q_at(en_coeff, k), k + 1);
    end
    check("run_n_done",   done_cyc.size(), 1);
    check("run_done_cyc", q_at(done_cyc, 0), 13);
    check("run_n_busy",   busy_cyc.size(), 12);
    check("run_busy_lo",  q_at(busy_cyc, 0), 1);
    check("run_busy_hi",  q_at(busy_cyc, 11), 12);
    check("run_stable",   viol, 0);

    // start held for 20 cycles: two runs, start in DONE not honoured
    begin_run();
    bus_a.start = 1'b1;
    run_until(20);
    bus_a.start = 1'b0;
    run_until(40);
    check("hold_n_done",    done_cyc.size(), 2);
    check("hold_done0",     q_at(done_cyc, 0), 13);
    check("hold_done1",     q_at(done_cyc, 1), 27);
    check("hold_n_strobe",  en_cyc.size(), 8);
    check("hold_run2_busy", q_at(busy_cyc, 12), 15);
    check("hold_run2_en",   q_at(en_cyc, 4), 16);
    check("hold_stable",    viol, 0);

    // Abort in a HOLD cycle
    begin_run();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    run_until(6);
    bus_a.abort = 1'b1;
    step();
    bus_a.abort = 1'b0;
    check("abort_busy",  int'(bus_a.busy),      0);
    check("abort_en",    int'(bus_a.en_out),    0);
    check("abort_sel",   int'(bus_a.sel_out),   1);
    check("abort_coeff", int'(bus_a.coeff_out), 2);
    run_until(20);
    check("abort_n_strobe", en_cyc.size(), 2);
    check("abort_n_done",   done_cyc.size(), 0);

    // abort beats start in the same idle cycle
    begin_run();
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check("prio_busy", int'(bus_a.busy), 0);
    run_until(6);
    check("prio_n_strobe", en_cyc.size(), 0);

    // coeff_flat changed after capture
    bus_a.coeff_flat = {5'd4, 5'd3, 5'd2, 5'd1};
    begin_run();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    run_until(3);
    bus_a.coeff_flat = '1;
    run_until(16);
    for (int k = 0; k < 4; k++)
      check($sformatf("snap_coeff%0d", k), q_at(en_coeff, k), k + 1);
    check("snap_done_cyc", q_at(done_cyc, 0), 13);

    // Reset asserted during a STROBE cycle
    bus_a.coeff_flat = {5'd4, 5'd3, 5'd2, 5'd1};
    begin_run();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    run_until(5);
    check("mid_en_pre", int'(bus_a.en_out), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_en",    int'(bus_a.en_out),    0);
    check("mid_rst_busy",  int'(bus_a.busy),      0);
    check("mid_rst_done",  int'(bus_a.done),      0);
    check("mid_rst_sel",   int'(bus_a.sel_out),   0);
    check("mid_rst_coeff", int'(bus_a.coeff_out), 0);
    step();
    rst_n = 1'b1;
    run_until(12);
    check("mid_idle_busy",  int'(bus_a.busy), 0);
    check("mid_n_strobe",   en_cyc.size(), 2);
    check("mid_n_done",     done_cyc.size(), 0);

    // GAP=3, two slots
    mon_b = 1'b1;
    bus_b.coeff_flat = {5'd9, 5'd6};
    begin_run();
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    run_until(14);
    check("gap_n_strobe", en_cyc.size(), 2);
    check("gap_en0",      q_at(en_cyc, 0), 2);
    check("gap_en1",      q_at(en_cyc, 1), 7);
    check("gap_sel0",     q_at(en_sel, 0), 0);
    check("gap_sel1",     q_at(en_sel, 1), 1);
    check("gap_coeff0",   q_at(en_coeff, 0), 6);
    check("gap_coeff1",   q_at(en_coeff, 1), 9);
    check("gap_done_cyc", q_at(done_cyc, 0), 11);
    check("gap_n_busy",   busy_cyc.size(), 10);
    check("gap_stable",   viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
